// File: rtl/inertial_integrator_cal.sv
// inertial_integrator_cal: complementary-filter pitch integrator with run-time offset calibration.
// Optional macro INERT_INTEG_SAT_EN: clamp the integrator instead of wrapping on overflow.
module inertial_integrator_cal #(
    parameter int DW          = 16,
    parameter int FRAC        = 11,
    parameter int CAL_LOG2    = 4,
    parameter int FUSION_STEP = 1024,
    parameter int ACC_GAIN    = 327,
    parameter int ACC_SHIFT   = 13,
    parameter logic signed [DW-1:0] RT_OFF_DFLT = 16'h0050,
    parameter logic signed [DW-1:0] AZ_OFF_DFLT = 16'h00A0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld,
    input  logic                 cal_start,
    input  logic signed [DW-1:0] ptch_rt,
    input  logic signed [DW-1:0] AZ,
    output logic signed [DW-1:0] ptch,
    output logic                 ptch_vld,
    output logic                 cal_busy,
    output logic                 cal_done
);
    localparam int IW    = DW + FRAC;
    localparam int SW    = DW + CAL_LOG2;
    localparam int PW    = DW + 33;
    localparam int CAL_N = 1 << CAL_LOG2;

    typedef enum logic {RUN, CAL} state_t;
    state_t state, state_nxt;

    logic signed [IW-1:0]     ptch_int, int_nxt;
    logic signed [DW-1:0]     rt_off, az_off;
    logic signed [SW-1:0]     sum_rt, sum_az, sum_rt_n, sum_az_n, avg_rt, avg_az;
    logic        [CAL_LOG2:0] cnt;
    logic signed [DW:0]       rt_comp, az_comp;
    logic signed [PW-1:0]     prod, acc;
    logic signed [IW+1:0]     step, nxt;
    logic                     cal_acc, cal_fin, run_upd;

    assign cal_acc = state == CAL && vld && !cal_start;
    assign cal_fin = cal_acc && cnt == (CAL_LOG2+1)'(CAL_N - 1);
    assign run_upd = state == RUN && vld && !cal_start;
    assign cal_busy = state == CAL;
    assign ptch = ptch_int[IW-1:FRAC];

    // The average includes the sample that completes the window.
    assign sum_rt_n = sum_rt + SW'(ptch_rt);
    assign sum_az_n = sum_az + SW'(AZ);
    assign avg_rt = sum_rt_n >>> CAL_LOG2;
    assign avg_az = sum_az_n >>> CAL_LOG2;

    assign rt_comp = (DW+1)'(ptch_rt) - (DW+1)'(rt_off);
    assign az_comp = (DW+1)'(AZ) - (DW+1)'(az_off);
    assign prod = PW'(az_comp) * PW'(ACC_GAIN);
    assign acc = prod >>> ACC_SHIFT;
    assign step = (acc > PW'(ptch)) ? (IW+2)'(FUSION_STEP) : -(IW+2)'(FUSION_STEP);
    assign nxt = (IW+2)'(ptch_int) - (IW+2)'(rt_comp) + step;

`ifdef INERT_INTEG_SAT_EN
    // Top three bits disagree only when the sum left the IW-bit signed range.
    assign int_nxt = (nxt[IW+1:IW-1] == {3{nxt[IW+1]}}) ? nxt[IW-1:0] :
                     nxt[IW+1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
`else
    assign int_nxt = nxt[IW-1:0];
`endif

    always_comb begin
        state_nxt = state;
        if (cal_start)
            state_nxt = CAL;
        else if (cal_fin)
            state_nxt = RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            ptch_int <= '0;
            rt_off   <= RT_OFF_DFLT;
            az_off   <= AZ_OFF_DFLT;
            sum_rt   <= '0;
            sum_az   <= '0;
            cnt      <= '0;
            ptch_vld <= 1'b0;
            cal_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptch_vld <= run_upd;
            cal_done <= cal_fin;
            if (cal_start) begin
                sum_rt <= '0;
                sum_az <= '0;
                cnt    <= '0;
            end else if (cal_acc) begin
                sum_rt <= sum_rt_n;
                sum_az <= sum_az_n;
                cnt    <= cnt + 1'b1;
                if (cal_fin) begin
                    rt_off   <= avg_rt[DW-1:0];
                    az_off   <= avg_az[DW-1:0];
                    ptch_int <= '0;
                end
            end else if (run_upd) begin
                ptch_int <= int_nxt;
            end
        end
    end
endmodule

// File: tb/tb_inertial_integrator_cal.sv
// tb_inertial_integrator_cal: directed vectors with a queue scoreboard for ptch and cal_done.
module tb_inertial_integrator_cal;
    logic        clk = 1'b0, rst = 1'b1, vld = 1'b0, cal_start = 1'b0;
    logic [15:0] ptch_rt = '0, AZ = '0;
    logic [15:0] ptch;
    logic        ptch_vld, cal_busy, cal_done;

    int checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    bit          done_q[$];

    longint m_int;
    int     rt_off, az_off, sum_rt, sum_az, cnt;
    bit     cal;

    localparam longint IMAX = (longint'(1) << 26) - 1;
    localparam longint IMIN = -(longint'(1) << 26);

    inertial_integrator_cal dut (
        .clk(clk), .rst(rst), .vld(vld), .cal_start(cal_start),
        .ptch_rt(ptch_rt), .AZ(AZ), .ptch(ptch), .ptch_vld(ptch_vld),
        .cal_busy(cal_busy), .cal_done(cal_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        m_int = 0; rt_off = 32'h50; az_off = 32'hA0;
        sum_rt = 0; sum_az = 0; cnt = 0; cal = 0;
    endtask

    task automatic model(input logic [15:0] r, input logic [15:0] a, input bit v, input bit cs);
        int sr, sa;
        longint rc, ac, acc, p, n;
        sr = $signed(r);
        sa = $signed(a);
        if (cs) begin
            cal = 1; sum_rt = 0; sum_az = 0; cnt = 0;
        end else if (v && cal) begin
            sum_rt += sr; sum_az += sa; cnt++;
            if (cnt == 16) begin
                rt_off = sum_rt >>> 4; az_off = sum_az >>> 4;
                m_int = 0; cal = 0;
                done_q.push_back(1'b1);
            end
        end else if (v) begin
            rc = sr - rt_off;
            ac = sa - az_off;
            acc = (ac * 327) >>> 13;
            p = m_int >>> 11;
            n = m_int - rc + ((acc > p) ? 1024 : -1024);
`ifdef INERT_INTEG_SAT_EN
            if (n > IMAX) n = IMAX;
            if (n < IMIN) n = IMIN;
`else
            n = (n <<< 37) >>> 37;
`endif
            m_int = n;
            exp_q.push_back(16'(m_int >>> 11));
        end
    endtask

    task automatic issue(input logic [15:0] r, input logic [15:0] a, input bit v, input bit cs);
        @(negedge clk);
        ptch_rt = r; AZ = a; vld = v; cal_start = cs;
        model(r, a, v, cs);
        @(negedge clk);
        vld = 1'b0; cal_start = 1'b0;
        chk("cal_busy", cal_busy, cal);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ptch_vld) begin
                if (exp_q.size() == 0) chk("ptch_vld_spurious", ptch_vld, 0);
                else chk("ptch", ptch, exp_q.pop_front());
            end
            if (cal_done) begin
                if (done_q.size() == 0) chk("cal_done_spurious", cal_done, 0);
                else chk("cal_done", cal_done, done_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] prev;
        bit pos_seen, went_neg;
        reset_model();
        repeat (3) @(negedge clk);
        chk("rst_ptch", ptch, 0);
        chk("rst_ptch_vld", ptch_vld, 0);
        chk("rst_cal_busy", cal_busy, 0);
        chk("rst_cal_done", cal_done, 0);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) issue(16'h0050, 16'h00A0, 1, 0);

        issue(16'h0850, 16'h00A0, 1, 0);
        chk("t2_first", ptch, 16'hFFFE);
        for (int i = 0; i < 9; i++) begin
            prev = ptch;
            issue(16'h0850, 16'h00A0, 1, 0);
            chk("t2_nonincr", 32'($signed(ptch) <= $signed(prev)), 1);
        end
        chk("t2_last", ptch, 16'hFFFA);

        issue(16'h0, 16'h0, 0, 1);
        for (int i = 0; i < 16; i++) issue(16'h0060, 16'h0100, 1, 0);
        issue(16'h0060, 16'h0100, 1, 0);
        chk("t3_first", ptch, 16'hFFFF);
        for (int i = 0; i < 19; i++) issue(16'h0060, 16'h0100, 1, 0);

        issue(16'h0, 16'h0, 0, 1);
        for (int i = 0; i < 5; i++) issue(16'(16'h0040 + i), 16'(16'h0090 + 2 * i), 1, 0);
        issue(16'h7FFF, 16'h7FFF, 1, 1);
        for (int i = 0; i < 15; i++) issue(16'(16'h0038 + 3 * i), 16'(16'h00B0 - i), 1, 0);
        chk("t4_cal_done_low", cal_done, 0);
        issue(16'h0070, 16'h00C0, 1, 0);
        for (int i = 0; i < 10; i++) issue(16'(16'h0040 + 5 * i), 16'(16'h0200 + 16 * i), 1, 0);

        issue(16'h0, 16'h0, 0, 1);
        for (int i = 0; i < 8; i++) issue(16'h1234, 16'h0400, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        @(negedge clk);
        chk("t5_ptch", ptch, 0);
        chk("t5_ptch_vld", ptch_vld, 0);
        chk("t5_cal_busy", cal_busy, 0);
        chk("t5_cal_done", cal_done, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) issue(16'h0050, 16'h00A0, 1, 0);

        pos_seen = 0; went_neg = 0;
        for (int i = 0; i < 2300; i++) begin
            issue(16'h8000, 16'h00A0, 1, 0);
            if ($signed(ptch) > 0) pos_seen = 1;
            else if (pos_seen && ptch[15]) went_neg = 1;
        end
`ifdef INERT_INTEG_SAT_EN
        chk("t6_sat", ptch, 16'h7FFF);
`else
        chk("t6_wrap", 32'(went_neg), 1);
`endif

        repeat (3) @(negedge clk);
        chk("ptch_q_drained", exp_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
